// File: rtl/alu_md_unit.sv
// Execute-stage ALU with registered single-cycle ops plus iterative unsigned
// MULTU/DIVU into HI/LO; busy stalls issue while a multi-cycle op runs.
module alu_md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
        OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO
    } op_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    op_t              op;
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        op = OP_AND;
        case (aluop)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b101010: op = OP_SLT;
                    6'b011001: op = OP_MULTU;
                    6'b011011: op = OP_DIVU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    default:   op = OP_AND;
                endcase
            end
            default: op = OP_AND;
        endcase
    end

    always_comb begin
        alu_res = a & b;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = a & b;
        endcase
    end

    // Multiply: acc holds the running high half, work shifts the multiplier
    // out of its LSB while product bits enter from the top.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_nxt, mul_work_nxt;
    assign mul_sum      = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc_nxt  = mul_sum[WIDTH:1];
    assign mul_work_nxt = {mul_sum[0], work_q[WIDTH-1:1]};

    // Divide: acc is the partial remainder, work shifts the dividend out of
    // its MSB and quotient bits in at the LSB. A zero divisor yields q=~0, r=a.
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_diff, div_acc_nxt, div_work_nxt;
    logic             div_ge;
    assign div_trial    = {acc_q, work_q[WIDTH-1]};
    assign div_ge       = div_trial >= {1'b0, opnd_q};
    assign div_diff     = div_trial[WIDTH-1:0] - opnd_q;
    assign div_acc_nxt  = div_ge ? div_diff : div_trial[WIDTH-1:0];
    assign div_work_nxt = {work_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        work_d      = work_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MULTU) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        work_d  = b;
                        opnd_d  = a;
                    end else if (op == OP_DIVU) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        acc_d   = '0;
                        work_d  = a;
                        opnd_d  = b;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d  = mul_acc_nxt;
                work_d = mul_work_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = S_DONE;
                    cnt_d       = '0;
                    hi_d        = mul_acc_nxt;
                    lo_d        = mul_work_nxt;
                    result_d    = mul_work_nxt;
                    zero_d      = (mul_work_nxt == '0);
                    out_valid_d = 1'b1;
                end
            end
            S_DIV: begin
                acc_d  = div_acc_nxt;
                work_d = div_work_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d     = S_DONE;
                    cnt_d       = '0;
                    hi_d        = div_acc_nxt;
                    lo_d        = div_work_nxt;
                    result_d    = div_work_nxt;
                    zero_d      = (div_work_nxt == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            work_q      <= '0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            work_q      <= work_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit: a 32-bit instance for single-cycle vectors and an
// 8-bit instance for MULTU/DIVU, HI/LO readback and mid-operation reset.
module tb_alu_md_unit;

    localparam int W8 = 8;

    logic        clk;
    logic        rst;

    logic        iv32;
    logic [1:0]  op32;
    logic [5:0]  fn32;
    logic [31:0] a32, b32;
    logic [31:0] r32, hi32, lo32;
    logic        z32, ov32, bz32;

    logic        iv8;
    logic [1:0]  op8;
    logic [5:0]  fn8;
    logic [7:0]  a8, b8;
    logic [7:0]  r8, hi8, lo8;
    logic        z8, ov8, bz8;

    alu_md_unit #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .aluop(op32), .funct(fn32),
        .a(a32), .b(b32), .result(r32), .zero(z32), .out_valid(ov32),
        .busy(bz32), .hi(hi32), .lo(lo32)
    );

    alu_md_unit #(.WIDTH(W8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .aluop(op8), .funct(fn8),
        .a(a8), .b(b8), .result(r8), .zero(z8), .out_valid(ov8),
        .busy(bz8), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        hl;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    exp_t q32[$];
    exp_t q8[$];
    vec_t vecs[12];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR = 6'b100101, F_SLT = 6'b101010, F_MULTU = 6'b011001,
                           F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MFLO = 6'b010010;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic push8(input logic [7:0] r, input logic hl, input logic [7:0] h,
                         input logic [7:0] l);
        exp_t e;
        e.res = {24'b0, r};
        e.z   = (r == 8'd0);
        e.hl  = hl;
        e.hi  = {24'b0, h};
        e.lo  = {24'b0, l};
        q8.push_back(e);
    endtask

    // Advance one clock, then compare any produced outputs against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (ov32) begin
            if (q32.size() == 0) begin
                chk("u32_unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = q32.pop_front();
                chk("u32_result", r32, e.res);
                chk("u32_zero", {31'b0, z32}, {31'b0, e.z});
            end
        end
        if (ov8) begin
            if (q8.size() == 0) begin
                chk("u8_unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("u8_result", {24'b0, r8}, e.res);
                chk("u8_zero", {31'b0, z8}, {31'b0, e.z});
                if (e.hl) begin
                    chk("u8_hi", {24'b0, hi8}, e.hi);
                    chk("u8_lo", {24'b0, lo8}, e.lo);
                end
            end
        end
    endtask

    task automatic drive8(input logic [1:0] op, input logic [5:0] fn,
                          input logic [7:0] av, input logic [7:0] bv);
        iv8 = 1'b1;
        op8 = op;
        fn8 = fn;
        a8  = av;
        b8  = bv;
    endtask

    // Issue a multi-cycle op on the 8-bit unit and walk it to the first free cycle.
    task automatic run_md8(input logic [5:0] fn, input logic [7:0] av, input logic [7:0] bv);
        drive8(2'b10, fn, av, bv);
        for (int c = 1; c <= W8 + 2; c++) begin
            tick();
            if (c == 1) iv8 = 1'b0;
            chk("u8_busy", {31'b0, bz8}, {31'b0, (c <= W8 + 1)});
            chk("u8_out_valid", {31'b0, ov8}, {31'b0, (c == W8 + 1)});
        end
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] prod;
        logic [5:0]  rfn;

        rst = 1'b1;
        iv32 = 1'b0; op32 = 2'b00; fn32 = 6'd0; a32 = 32'd0; b32 = 32'd0;
        iv8 = 1'b0;  op8 = 2'b00;  fn8 = 6'd0;  a8 = 8'd0;   b8 = 8'd0;

        vecs[0]  = '{2'b10, F_SUB,   32'd5,        32'd5,        32'd0,        1'b1};
        vecs[1]  = '{2'b10, F_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[2]  = '{2'b10, 6'h3F,   32'hF0,       32'h3C,       32'h30,       1'b0};
        vecs[3]  = '{2'b00, 6'h00,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[4]  = '{2'b01, 6'h00,   32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{2'b11, F_ADD,   32'hF0F0,     32'hFF00,     32'hF000,     1'b0};
        vecs[6]  = '{2'b10, F_ADD,   32'd7,        32'd8,        32'd15,       1'b0};
        vecs[7]  = '{2'b10, F_OR,    32'hF0,       32'h0F,       32'hFF,       1'b0};
        vecs[8]  = '{2'b10, F_AND,   32'h0C,       32'h0A,       32'h08,       1'b0};
        vecs[9]  = '{2'b10, F_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
        vecs[10] = '{2'b10, F_SLT,   32'd2,        32'd3,        32'd1,        1'b0};
        vecs[11] = '{2'b10, F_SUB,   32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_u32_result", r32, 32'd0);
        chk("rst_u32_flags", {28'b0, z32, ov32, bz32, 1'b0}, 32'd0);
        chk("rst_u32_hilo", hi32 | lo32, 32'd0);
        chk("rst_u8_result", {24'b0, r8}, 32'd0);
        chk("rst_u8_flags", {28'b0, z8, ov8, bz8, 1'b0}, 32'd0);
        chk("rst_u8_hilo", {16'b0, hi8, lo8}, 32'd0);

        // Back-to-back single-cycle ops, one result per cycle.
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            iv32 = 1'b1;
            op32 = vecs[i].aluop;
            fn32 = vecs[i].funct;
            a32  = vecs[i].a;
            b32  = vecs[i].b;
            e.res = vecs[i].res; e.z = vecs[i].z; e.hl = 1'b0; e.hi = 32'd0; e.lo = 32'd0;
            q32.push_back(e);
            tick();
            chk("u32_vec_out_valid", {31'b0, ov32}, 32'd1);
            chk("u32_busy", {31'b0, bz32}, 32'd0);
        end
        iv32 = 1'b0;
        tick();
        chk("u32_idle_out_valid", {31'b0, ov32}, 32'd0);

        // MULTU 0xFF*0xFF with requests held during busy, which must be dropped.
        push8(8'h01, 1'b1, 8'hFE, 8'h01);
        drive8(2'b10, F_MULTU, 8'hFF, 8'hFF);
        for (int c = 1; c <= W8 + 2; c++) begin
            tick();
            if (c == 1) drive8(2'b00, F_ADD, 8'd1, 8'd1);
            if (c == W8 + 2) iv8 = 1'b0;
            chk("mul_ff_busy", {31'b0, bz8}, {31'b0, (c <= W8 + 1)});
            chk("mul_ff_out_valid", {31'b0, ov8}, {31'b0, (c == W8 + 1)});
        end
        tick();
        chk("mul_ff_no_extra", {31'b0, ov8}, 32'd0);

        push8(8'd14, 1'b1, 8'd2, 8'd14);
        run_md8(F_DIVU, 8'd100, 8'd7);
        push8(8'hFF, 1'b1, 8'd100, 8'hFF);
        run_md8(F_DIVU, 8'd100, 8'd0);

        // Random MULTU/DIVU against an arithmetic reference.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i == 5) ? 8'd0 : 8'($urandom_range(0, 255));
            if (i[0]) begin
                rfn  = F_DIVU;
                prod = (rb == 8'd0) ? {ra, 8'hFF} : {ra % rb, ra / rb};
            end else begin
                rfn  = F_MULTU;
                prod = 16'(ra) * 16'(rb);
            end
            push8(prod[7:0], 1'b1, prod[15:8], prod[7:0]);
            run_md8(rfn, ra, rb);
        end

        // MULTU then immediate MFLO/MFHI readback.
        push8(8'd12, 1'b1, 8'd0, 8'd12);
        run_md8(F_MULTU, 8'd3, 8'd4);
        drive8(2'b10, F_MFLO, 8'hAA, 8'h55);
        push8(8'd12, 1'b0, 8'd0, 8'd0);
        tick();
        chk("mflo_out_valid", {31'b0, ov8}, 32'd1);
        drive8(2'b10, F_MFHI, 8'hAA, 8'h55);
        push8(8'd0, 1'b0, 8'd0, 8'd0);
        tick();
        chk("mfhi_out_valid", {31'b0, ov8}, 32'd1);
        iv8 = 1'b0;
        tick();

        // Reset mid-MULTU, with a request presented alongside reset.
        drive8(2'b10, F_MULTU, 8'd9, 8'd9);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) iv8 = 1'b0;
        end
        rst = 1'b1;
        drive8(2'b00, F_ADD, 8'd1, 8'd1);
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'b0, bz8}, 32'd0);
        chk("abort_out_valid", {31'b0, ov8}, 32'd0);
        chk("abort_hilo", {16'b0, hi8, lo8}, 32'd0);
        drive8(2'b00, F_ADD, 8'd2, 8'd3);
        push8(8'd5, 1'b0, 8'd0, 8'd0);
        tick();
        chk("post_abort_out_valid", {31'b0, ov8}, 32'd1);
        iv8 = 1'b0;
        repeat (2) tick();

        chk("u32_queue_drained", q32.size(), 32'd0);
        chk("u8_queue_drained", q8.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
